ifu_fetch: RTL and testbench

//   Instruction-fetch stage directly downstream of the PC register. Takes pc/ce, issues
//   one-outstanding fetch requests to instruction memory (valid/ready request, valid-only

---
 rtl/ifu_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage that sits directly after the PC register.
//   Captures pc_i_ifu when ce_i_ifu is high and buffer space exists, and issues
//   one outstanding request to instruction memory (valid/ready request, valid-only
//   response). It queues {pc, inst} pairs in a small FIFO that feeds decode
//   through a valid/ready interface. A flush discards queued entries and
//   drops any response that is still in flight.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ce_i_ifu, pc_i_ifu                PC valid / PC value from the PC register
//   flush_i_ifu                       branch redirect
//   stall_o_ifu                       0 only in a cycle where the PC is consumed
//   imem_req_valid_o/ready_i/addr_o   fetch request channel
//   imem_rsp_valid_i/data_i           fetch response channel (valid only)
//   inst_valid_o/ready_i, inst_o,
//   inst_pc_o                         FIFO head towards decode
// Optional feature macro IFU_MISALIGN_CHECK_EN adds misalign_o. When the macro
//   is defined, a PC with pc[1:0] != 0 skips memory and pushes a NOP entry that
//   is flagged as misaligned.
module ifu_fetch #(
  parameter int ADDR_W    = 64,
  parameter int INST_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i_ifu,
  input  logic [ADDR_W-1:0] pc_i_ifu,
  input  logic              flush_i_ifu,
  output logic              stall_o_ifu,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic [INST_W-1:0] last_inst_q, last_inst_d;

  logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
  logic [INST_W-1:0] inst_mem [BUF_DEPTH];

  logic              head_valid, push, pop, capture, pc_aligned;
  logic [ADDR_W-1:0] push_pc;
  logic [INST_W-1:0] push_inst;
  logic [CNT_W-1:0]  count_after;

`ifdef IFU_MISALIGN_CHECK_EN
  logic mis_mem [BUF_DEPTH];
  logic last_mis_q, last_mis_d, push_mis;
  assign pc_aligned = (pc_i_ifu[1:0] == 2'b00);
`else
  assign pc_aligned = 1'b1;
`endif

  assign head_valid = (count_q != '0);
  assign pop        = head_valid && inst_ready_i && !flush_i_ifu;
  // Occupancy once this cycle's response is pushed and any pop retires.
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    push      = 1'b0;
    push_pc   = addr_q;
    push_inst = imem_rsp_data_i;
    capture   = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    push_mis  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Nothing is in flight in IDLE, so only queued entries use up slots.
        if (ce_i_ifu && !flush_i_ifu && (count_q < DEPTH_C)) begin
          capture = 1'b1;
          if (pc_aligned) begin
            addr_d  = pc_i_ifu;
            state_d = S_REQ;
          end else begin
`ifdef IFU_MISALIGN_CHECK_EN
            push      = 1'b1;
            push_pc   = pc_i_ifu;
            push_inst = INST_W'(32'h0000_0013);
            push_mis  = 1'b1;
`endif
          end
        end
      end
      S_REQ: begin
        // The request stays up during a flush cycle. If it is accepted in that
        // cycle, its response is still owed and must be drained.
        if (imem_req_ready_i) state_d = flush_i_ifu ? S_DRAIN : S_WAIT;
        else if (flush_i_ifu) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (flush_i_ifu) begin
            state_d = S_IDLE;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
            if (ce_i_ifu && pc_aligned && (count_after < DEPTH_C)) begin
              capture = 1'b1;
              addr_d  = pc_i_ifu;
              state_d = S_REQ;
            end
          end
        end else if (flush_i_ifu) begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        if (imem_rsp_valid_i) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    last_pc_d   = last_pc_q;
    last_inst_d = last_inst_q;
`ifdef IFU_MISALIGN_CHECK_EN
    last_mis_d  = last_mis_q;
`endif
    // Remember the departing head so that the outputs hold once the FIFO is empty.
    if (head_valid && (pop || flush_i_ifu)) begin
      last_pc_d   = pc_mem[rd_ptr_q];
      last_inst_d = inst_mem[rd_ptr_q];
`ifdef IFU_MISALIGN_CHECK_EN
      last_mis_d  = mis_mem[rd_ptr_q];
`endif
    end
    if (flush_i_ifu) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_pc_q   <= '0;
      last_inst_q <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      last_mis_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_pc_q   <= last_pc_d;
      last_inst_q <= last_inst_d;
`ifdef IFU_MISALIGN_CHECK_EN
      last_mis_q  <= last_mis_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      inst_mem[wr_ptr_q] <= push_inst;
`ifdef IFU_MISALIGN_CHECK_EN
      mis_mem[wr_ptr_q]  <= push_mis;
`endif
    end
  end

  assign stall_o_ifu      = rst || !capture;
  assign imem_req_valid_o = (state_q == S_REQ);
  assign imem_addr_o      = addr_q;
  assign inst_valid_o     = head_valid;
  assign inst_o           = head_valid ? inst_mem[rd_ptr_q] : last_inst_q;
  assign inst_pc_o        = head_valid ? pc_mem[rd_ptr_q] : last_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_o       = head_valid ? mis_mem[rd_ptr_q] : last_mis_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst, ce, flush, stall;
  logic [63:0] pc;
  logic        req_valid, req_ready;
  logic [63:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  // Memory model: automatic zero-wait replies, or manually driven replies.
  logic        mem_auto, auto_vld, man_vld;
  logic [31:0] auto_data, man_data;
  assign rsp_valid = mem_auto ? auto_vld : man_vld;
  assign rsp_data  = mem_auto ? auto_data : man_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vecs[4];

  ifu_fetch #(.ADDR_W(64), .INST_W(32), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ce_i_ifu(ce), .pc_i_ifu(pc), .flush_i_ifu(flush),
    .stall_o_ifu(stall), .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
    .imem_addr_o(addr), .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_o(inst),
    .inst_pc_o(inst_pc)
`ifdef IFU_MISALIGN_CHECK_EN
    , .misalign_o(misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: mem_word = 32'h0000_0413;
      64'h8000_0004: mem_word = 32'h0050_0093;
      64'h8000_0008: mem_word = 32'h00a0_0113;
      64'h8000_1000: mem_word = 32'h0000_006f;
      default:       mem_word = 32'hdead_beef;
    endcase
  endfunction

  always @(posedge clk) begin
    auto_vld  <= req_valid && req_ready;
    auto_data <= mem_word(addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Capture one PC and wait for its entry to reach the FIFO with a zero-wait memory.
  task automatic fetch_one(input logic [63:0] p);
    ce = 1'b1; pc = p;
    #1 check("capture_stall", 64'(stall), 64'd0);
    tick(); ce = 1'b0;
    tick(); tick();
  endtask

  initial begin
    vecs[0] = '{64'h8000_0000, 32'h0000_0413};
    vecs[1] = '{64'h8000_0004, 32'h0050_0093};
    vecs[2] = '{64'h8000_0008, 32'h00a0_0113};
    vecs[3] = '{64'h8000_1000, 32'h0000_006f};

    rst = 1'b1; ce = 1'b0; flush = 1'b0; pc = '0; req_ready = 1'b1;
    inst_ready = 1'b0; mem_auto = 1'b1; man_vld = 1'b0; man_data = '0;
    tick(); tick();
    check("rst_stall", 64'(stall), 64'd1);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_addr", addr, 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    rst = 1'b0;
    tick();

    // Single fetches, each followed by a pop that leaves the head value held.
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1; pc = vecs[i].pc;
      #1 check("vec_capture_stall", 64'(stall), 64'd0);
      tick(); ce = 1'b0;
      check("vec_req_valid", 64'(req_valid), 64'd1);
      check("vec_addr", addr, vecs[i].pc);
      tick();
      check("vec_not_yet_valid", 64'(inst_valid), 64'd0);
      tick();
      check("vec_inst_valid", 64'(inst_valid), 64'd1);
      check("vec_inst", 64'(inst), 64'(vecs[i].exp_inst));
      check("vec_inst_pc", inst_pc, vecs[i].pc);
      inst_ready = 1'b1;
      tick(); inst_ready = 1'b0;
      check("vec_popped_empty", 64'(inst_valid), 64'd0);
      check("vec_hold_inst", 64'(inst), 64'(vecs[i].exp_inst));
      check("vec_hold_pc", inst_pc, vecs[i].pc);
    end

    // The FIFO fills to two entries and the third PC is held off.
    begin
      int idx = 0;
      logic [63:0] plist [3];
      plist[0] = 64'h8000_0000; plist[1] = 64'h8000_0004; plist[2] = 64'h8000_0008;
      ce = 1'b1; pc = plist[0];
      for (int c = 0; c < 12; c++) begin
        #1;
        if (!stall && idx < 2) begin
          tick(); idx++; pc = plist[idx];
        end else begin
          tick();
        end
      end
      check("full_captures", 64'(idx), 64'd2);
      #1 check("full_stall", 64'(stall), 64'd1);
      check("full_req_valid", 64'(req_valid), 64'd0);
      check("full_head_pc", inst_pc, 64'h8000_0000);
      check("full_head_inst", 64'(inst), 64'h0000_0413);
      ce = 1'b0; inst_ready = 1'b1;
      tick();
      check("drain_second_pc", inst_pc, 64'h8000_0004);
      check("drain_second_inst", 64'(inst), 64'h0050_0093);
      tick(); inst_ready = 1'b0;
      check("drain_empty", 64'(inst_valid), 64'd0);
    end

    // A back-pressured request keeps its address stable.
    req_ready = 1'b0; ce = 1'b1; pc = 64'h8000_0008;
    tick(); ce = 1'b0; pc = 64'h0;
    for (int c = 0; c < 5; c++) begin
      check("bp_req_valid", 64'(req_valid), 64'd1);
      check("bp_addr", addr, 64'h8000_0008);
      tick();
    end
    req_ready = 1'b1;
    tick(); tick();
    check("bp_head_pc", inst_pc, 64'h8000_0008);
    check("bp_head_inst", 64'(inst), 64'h00a0_0113);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;

    // Flush in WAIT: the queued entry is cleared and a late response is dropped.
    fetch_one(64'h8000_0000);
    mem_auto = 1'b0;
    ce = 1'b1; pc = 64'h8000_0004;
    tick(); ce = 1'b0;
    tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("flush_cleared", 64'(inst_valid), 64'd0);
    check("flush_hold_inst", 64'(inst), 64'h0000_0413);
    tick(); tick();
    man_vld = 1'b1; man_data = 32'h0bad_0bad;
    tick(); man_vld = 1'b0;
    check("flush_rsp_dropped", 64'(inst_valid), 64'd0);
    mem_auto = 1'b1;
    fetch_one(64'h8000_1000);
    check("redirect_valid", 64'(inst_valid), 64'd1);
    check("redirect_pc", inst_pc, 64'h8000_1000);
    check("redirect_inst", 64'(inst), 64'h0000_006f);

    // Reset in WAIT, with the redirect entry still queued.
    mem_auto = 1'b0;
    ce = 1'b1; pc = 64'h8000_0008;
    tick(); ce = 1'b0;
    tick();
    rst = 1'b1; ce = 1'b1;
    #1 check("midrst_stall", 64'(stall), 64'd1);
    tick(); rst = 1'b0; ce = 1'b0;
    check("midrst_req_valid", 64'(req_valid), 64'd0);
    check("midrst_addr", addr, 64'd0);
    check("midrst_inst_valid", 64'(inst_valid), 64'd0);
    check("midrst_inst", 64'(inst), 64'd0);
    check("midrst_inst_pc", inst_pc, 64'd0);
    man_vld = 1'b1; man_data = 32'h1234_5678;
    tick(); man_vld = 1'b0;
    tick();
    check("midrst_stale_ignored", 64'(inst_valid), 64'd0);
    mem_auto = 1'b1;

`ifdef IFU_MISALIGN_CHECK_EN
    ce = 1'b1; pc = 64'h8000_0002;
    #1 check("mis_stall", 64'(stall), 64'd0);
    check("mis_no_req_now", 64'(req_valid), 64'd0);
    tick(); ce = 1'b0;
    check("mis_no_req", 64'(req_valid), 64'd0);
    check("mis_valid", 64'(inst_valid), 64'd1);
    check("mis_inst", 64'(inst), 64'h0000_0013);
    check("mis_pc", inst_pc, 64'h8000_0002);
    check("mis_flag", 64'(misalign), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
